// File: rtl/vending_machine_param.sv
// ---------------------------------------------------------------------------
// vending_machine_param
//   Multi-product vending controller. Credit is built up from 10/20/50/100
//   coins; a selection dispenses one of NUM_PROD products at its own price.
//   Remaining credit (after a sale, a cancel or an idle timeout) is paid back
//   one coin at a time to a hopper, largest coin first (50/20/10).
//
// Ports
//   i_clk, i_rst_n      clock (rising edge), asynchronous active-low reset
//   i_coin_valid/sel    coin insert strobe and denomination (0=10 1=20 2=50 3=100)
//   o_coin_reject       1-cycle pulse: the coin was not accepted
//   i_sel_valid/prod    product selection strobe and index
//   i_cancel            refund request
//   o_dispense_valid    1-cycle pulse with o_dispense_prod: release product
//   o_err_sel           1-cycle pulse: not enough credit or invalid index
//   o_change_valid/coin change coin offered to hopper (0=10 1=20 2=50)
//   i_change_ready      hopper takes the offered coin
//   o_credit            current credit
//   o_busy              dispensing or paying out change
// ---------------------------------------------------------------------------
module vending_machine_param #(
    parameter int                          NUM_PROD   = 4,
    parameter int                          PRICE_W    = 8,
    parameter logic [NUM_PROD*PRICE_W-1:0] PRICES     = {8'd50, 8'd30, 8'd20, 8'd10},
    parameter int                          MAX_CREDIT = 200,
    parameter int                          TIMEOUT    = 255
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_coin_valid,
    input  logic [1:0]                  i_coin_sel,
    output logic                        o_coin_reject,
    input  logic                        i_sel_valid,
    input  logic [$clog2(NUM_PROD)-1:0] i_sel_prod,
    input  logic                        i_cancel,
    output logic                        o_dispense_valid,
    output logic [$clog2(NUM_PROD)-1:0] o_dispense_prod,
    output logic                        o_err_sel,
    output logic                        o_change_valid,
    output logic [1:0]                  o_change_coin,
    input  logic                        i_change_ready,
    output logic [PRICE_W-1:0]          o_credit,
    output logic                        o_busy
);

    localparam int SW = $clog2(NUM_PROD);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_CREDIT   = 2'd1,
        S_DISPENSE = 2'd2,
        S_CHANGE   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [PRICE_W-1:0] credit_q, credit_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic               coin_reject_d, dispense_valid_d, err_sel_d;
    logic [SW-1:0]      dispense_prod_d;

    logic [PRICE_W:0]   coin_val;
    logic [PRICE_W:0]   coin_sum;     // one extra bit so the ceiling check cannot wrap
    logic               sel_ok;
    logic [PRICE_W-1:0] price;
    logic [PRICE_W-1:0] change_amt;
    logic [1:0]         change_code;

    // Coin value, selected price and the greedy change coin for the current credit.
    always_comb begin
        case (i_coin_sel)
            2'd0:    coin_val = (PRICE_W+1)'(10);
            2'd1:    coin_val = (PRICE_W+1)'(20);
            2'd2:    coin_val = (PRICE_W+1)'(50);
            default: coin_val = (PRICE_W+1)'(100);
        endcase
        coin_sum = {1'b0, credit_q} + coin_val;

        sel_ok = (int'(i_sel_prod) < NUM_PROD);
        price  = sel_ok ? PRICES[int'(i_sel_prod)*PRICE_W +: PRICE_W] : '0;

        if (credit_q >= PRICE_W'(50)) begin
            change_amt  = PRICE_W'(50);
            change_code = 2'd2;
        end else if (credit_q >= PRICE_W'(20)) begin
            change_amt  = PRICE_W'(20);
            change_code = 2'd1;
        end else begin
            change_amt  = PRICE_W'(10);
            change_code = 2'd0;
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d          = state_q;
        credit_d         = credit_q;
        timer_d          = '0;
        coin_reject_d    = 1'b0;
        dispense_valid_d = 1'b0;
        dispense_prod_d  = '0;
        err_sel_d        = 1'b0;

        case (state_q)
            S_IDLE, S_CREDIT: begin
                // Priority cancel > selection > coin; a coin losing arbitration is rejected.
                if (i_cancel) begin
                    coin_reject_d = i_coin_valid;
                    if (state_q == S_CREDIT) state_d = S_CHANGE;
                end else if (i_sel_valid) begin
                    coin_reject_d = i_coin_valid;
                    if (state_q == S_CREDIT && sel_ok && credit_q >= price) begin
                        credit_d         = credit_q - price;
                        dispense_valid_d = 1'b1;
                        dispense_prod_d  = i_sel_prod;
                        state_d          = S_DISPENSE;
                    end else begin
                        err_sel_d = 1'b1;
                    end
                end else if (i_coin_valid) begin
                    if (coin_sum <= (PRICE_W+1)'(MAX_CREDIT)) begin
                        credit_d = coin_sum[PRICE_W-1:0];
                        state_d  = S_CREDIT;
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end else if (state_q == S_CREDIT) begin
                    // The TIMEOUT-th consecutive quiet cycle triggers the refund.
                    if (timer_q == TW'(TIMEOUT - 1)) state_d = S_CHANGE;
                    else                             timer_d = timer_q + 1'b1;
                end
            end
            S_DISPENSE: begin
                coin_reject_d = i_coin_valid;
                state_d       = (credit_q != '0) ? S_CHANGE : S_IDLE;
            end
            S_CHANGE: begin
                coin_reject_d = i_coin_valid;
                if (i_change_ready) begin
                    credit_d = credit_q - change_amt;
                    if (credit_q == change_amt) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: registered state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q          <= S_IDLE;
            credit_q         <= '0;
            timer_q          <= '0;
            o_coin_reject    <= 1'b0;
            o_dispense_valid <= 1'b0;
            o_dispense_prod  <= '0;
            o_err_sel        <= 1'b0;
        end else begin
            state_q          <= state_d;
            credit_q         <= credit_d;
            timer_q          <= timer_d;
            o_coin_reject    <= coin_reject_d;
            o_dispense_valid <= dispense_valid_d;
            o_dispense_prod  <= dispense_prod_d;
            o_err_sel        <= err_sel_d;
        end
    end

    assign o_credit       = credit_q;
    assign o_change_valid = (state_q == S_CHANGE);
    assign o_change_coin  = o_change_valid ? change_code : 2'd0;
    assign o_busy         = (state_q == S_DISPENSE) || (state_q == S_CHANGE);

endmodule

// File: tb/tb_vending_machine_param.sv
// ---------------------------------------------------------------------------
// tb_vending_machine_param
//   Directed scenarios followed by random purchase/cancel traffic. Expected
//   behaviour comes from a credit-level model: a running credit total, the
//   price table, and the greedy coin list the refund should produce.
// ---------------------------------------------------------------------------
module tb_vending_machine_param;

    localparam int MAX_CREDIT = 200;
    localparam int TIMEOUT    = 255;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_coin_valid = 1'b0;
    logic [1:0] i_coin_sel = 2'd0;
    logic       i_sel_valid = 1'b0;
    logic [1:0] i_sel_prod = 2'd0;
    logic       i_cancel = 1'b0;
    logic       i_change_ready = 1'b0;
    logic       o_coin_reject, o_dispense_valid, o_err_sel, o_change_valid, o_busy;
    logic [1:0] o_dispense_prod, o_change_coin;
    logic [7:0] o_credit;

    int n_cmp = 0;
    int n_err = 0;
    int m_credit = 0;

    vending_machine_param dut (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .i_coin_valid     (i_coin_valid),
        .i_coin_sel       (i_coin_sel),
        .o_coin_reject    (o_coin_reject),
        .i_sel_valid      (i_sel_valid),
        .i_sel_prod       (i_sel_prod),
        .i_cancel         (i_cancel),
        .o_dispense_valid (o_dispense_valid),
        .o_dispense_prod  (o_dispense_prod),
        .o_err_sel        (o_err_sel),
        .o_change_valid   (o_change_valid),
        .o_change_coin    (o_change_coin),
        .i_change_ready   (i_change_ready),
        .o_credit         (o_credit),
        .o_busy           (o_busy)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic int coin_val(input logic [1:0] s);
        case (s)
            2'd0:    return 10;
            2'd1:    return 20;
            2'd2:    return 50;
            default: return 100;
        endcase
    endfunction

    function automatic int price_of(input logic [1:0] p);
        case (p)
            2'd0:    return 10;
            2'd1:    return 20;
            2'd2:    return 30;
            default: return 50;
        endcase
    endfunction

    function automatic int change_amount(input logic [1:0] c);
        case (c)
            2'd0:    return 10;
            2'd1:    return 20;
            2'd2:    return 50;
            default: return 999;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_coin_valid   = 1'b0;
        i_coin_sel     = 2'd0;
        i_sel_valid    = 1'b0;
        i_sel_prod     = 2'd0;
        i_cancel       = 1'b0;
        i_change_ready = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_reject"}, o_coin_reject, 0);
        check({tag, "_disp"}, o_dispense_valid, 0);
        check({tag, "_prod"}, o_dispense_prod, 0);
        check({tag, "_err"}, o_err_sel, 0);
        check({tag, "_chg_valid"}, o_change_valid, 0);
        check({tag, "_chg_coin"}, o_change_coin, 0);
        check({tag, "_credit"}, o_credit, 0);
        check({tag, "_busy"}, o_busy, 0);
    endtask

    // One cycle of user inputs while the machine is taking coins/selections.
    // outcome: 0 = stays in vending, 1 = product dispensed, 2 = refund started.
    task automatic apply(input bit cv, input logic [1:0] cs, input bit sv,
                         input logic [1:0] sp, input bit cn, output int outcome);
        bit exp_rej, exp_disp, exp_err;
        exp_rej  = 1'b0;
        exp_disp = 1'b0;
        exp_err  = 1'b0;
        outcome  = 0;
        if (cn) begin
            exp_rej = cv;
            if (m_credit > 0) outcome = 2;
        end else if (sv) begin
            exp_rej = cv;
            if (m_credit >= price_of(sp)) begin
                exp_disp = 1'b1;
                m_credit -= price_of(sp);
                outcome  = 1;
            end else begin
                exp_err = 1'b1;
            end
        end else if (cv) begin
            if (m_credit + coin_val(cs) <= MAX_CREDIT) m_credit += coin_val(cs);
            else                                       exp_rej = 1'b1;
        end
        i_coin_valid = cv;
        i_coin_sel   = cs;
        i_sel_valid  = sv;
        i_sel_prod   = sp;
        i_cancel     = cn;
        tick();
        clear_inputs();
        check("coin_reject", o_coin_reject, exp_rej);
        check("dispense_valid", o_dispense_valid, exp_disp);
        check("err_sel", o_err_sel, exp_err);
        if (exp_disp) check("dispense_prod", o_dispense_prod, sp);
        check("change_valid", o_change_valid, outcome == 2);
        check("busy", o_busy, outcome != 0);
        check("credit", o_credit, m_credit);
    endtask

    // Drain the refund: the coins must be the greedy 50/20/10 breakdown of the
    // credit, each one held until the hopper takes it.
    task automatic collect_change(input int ready_pct);
        int  q[$];
        int  rem, left, guard, err0;
        bit  r, cv;
        rem   = m_credit;
        left  = m_credit;
        guard = 0;
        while (rem > 0) begin
            if (rem >= 50)      begin q.push_back(50); rem -= 50; end
            else if (rem >= 20) begin q.push_back(20); rem -= 20; end
            else                begin q.push_back(10); rem -= 10; end
        end
        err0 = n_err;
        while (q.size() > 0 && guard < 300 && n_err == err0) begin
            check("chg_valid", o_change_valid, 1);
            check("chg_coin", change_amount(o_change_coin), q[0]);
            check("chg_credit", o_credit, left);
            check("chg_busy", o_busy, 1);
            r  = ($urandom_range(99) < ready_pct);
            cv = 1'($urandom_range(1));
            i_change_ready = r;
            i_coin_valid   = cv;
            i_coin_sel     = 2'($urandom_range(3));
            i_sel_valid    = 1'($urandom_range(1));
            i_cancel       = 1'($urandom_range(1));
            tick();
            clear_inputs();
            check("chg_coin_reject", o_coin_reject, cv);
            check("chg_no_dispense", o_dispense_valid, 0);
            check("chg_no_err", o_err_sel, 0);
            if (r) begin
                left -= q[0];
                void'(q.pop_front());
            end
            guard++;
        end
        check("chg_drained", q.size(), 0);
        m_credit = 0;
        check("chg_end_valid", o_change_valid, 0);
        check("chg_end_credit", o_credit, 0);
        check("chg_end_busy", o_busy, 0);
    endtask

    // The cycle spent in the dispense state, then any change.
    task automatic after_dispense();
        bit cv;
        cv = 1'($urandom_range(1));
        i_coin_valid = cv;
        i_coin_sel   = 2'($urandom_range(3));
        tick();
        clear_inputs();
        check("disp_coin_reject", o_coin_reject, cv);
        if (m_credit > 0) begin
            collect_change(70);
        end else begin
            check("disp_idle_valid", o_change_valid, 0);
            check("disp_idle_busy", o_busy, 0);
            check("disp_idle_credit", o_credit, 0);
        end
    endtask

    task automatic handle(input int outcome);
        if (outcome == 1)      after_dispense();
        else if (outcome == 2) collect_change(60);
    endtask

    task automatic quiet_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int oc;

        // Reset state
        repeat (2) @(posedge i_clk);
        #1;
        check_quiet("reset");
        i_rst_n = 1'b1;
        tick();
        check_quiet("after_release");

        // Selection with no credit
        apply(0, 2'd0, 1, 2'd0, 0, oc);

        // 1: coin 50, product 1 -> change 20 then 10
        apply(1, 2'd2, 0, 2'd0, 0, oc);
        apply(0, 2'd0, 1, 2'd1, 0, oc);
        check("t1_dispensed", oc, 1);
        handle(oc);

        // 2: fill to the ceiling, one more coin is rejected
        apply(1, 2'd3, 0, 2'd0, 0, oc);
        apply(1, 2'd3, 0, 2'd0, 0, oc);
        check("t2_full", o_credit, 200);
        apply(1, 2'd0, 0, 2'd0, 0, oc);
        apply(0, 2'd0, 0, 2'd0, 1, oc);
        handle(oc);

        // 3: insufficient credit, then top up and buy
        apply(1, 2'd1, 0, 2'd0, 0, oc);
        apply(0, 2'd0, 1, 2'd3, 0, oc);
        apply(1, 2'd2, 0, 2'd0, 0, oc);
        apply(0, 2'd0, 1, 2'd3, 0, oc);
        handle(oc);

        // Exact-price purchase leaves nothing to return
        apply(1, 2'd0, 0, 2'd0, 0, oc);
        apply(0, 2'd0, 1, 2'd0, 0, oc);
        handle(oc);

        // 4: refund of 100 with the hopper stalled for three cycles
        apply(1, 2'd3, 0, 2'd0, 0, oc);
        apply(0, 2'd0, 0, 2'd0, 1, oc);
        for (int i = 0; i < 3; i++) begin
            check("t4_hold_valid", o_change_valid, 1);
            check("t4_hold_coin", change_amount(o_change_coin), 50);
            check("t4_hold_credit", o_credit, 100);
            i_coin_valid = 1'b1;
            tick();
            clear_inputs();
            check("t4_busy_reject", o_coin_reject, 1);
        end
        collect_change(100);

        // 5a: idle timeout refunds after exactly TIMEOUT quiet cycles
        apply(1, 2'd0, 0, 2'd0, 0, oc);
        quiet_cycles(TIMEOUT - 1);
        check("t5_before_timeout", o_change_valid, 0);
        check("t5_before_credit", o_credit, 10);
        tick();
        check("t5_timeout_valid", o_change_valid, 1);
        check("t5_timeout_coin", change_amount(o_change_coin), 10);
        collect_change(100);

        // 5b: activity restarts the idle count
        apply(1, 2'd0, 0, 2'd0, 0, oc);
        quiet_cycles(200);
        apply(1, 2'd0, 0, 2'd0, 0, oc);
        quiet_cycles(200);
        check("t5_timer_cleared", o_change_valid, 0);
        apply(0, 2'd0, 0, 2'd0, 1, oc);
        handle(oc);

        // 5c: coin + selection + cancel together -> refund, coin rejected
        apply(1, 2'd2, 0, 2'd0, 0, oc);
        apply(1, 2'd0, 1, 2'd0, 1, oc);
        check("t5_combo_refund", oc, 2);
        handle(oc);

        // 6: asynchronous reset in the middle of a refund
        apply(1, 2'd3, 0, 2'd0, 0, oc);
        apply(0, 2'd0, 0, 2'd0, 1, oc);
        i_change_ready = 1'b1;
        tick();
        clear_inputs();
        check("t6_mid_credit", o_credit, 50);
        #2 i_rst_n = 1'b0;
        #1 check_quiet("t6_async");
        #2 i_rst_n = 1'b1;
        m_credit = 0;
        tick();
        check_quiet("t6_after");
        apply(1, 2'd0, 0, 2'd0, 0, oc);
        apply(0, 2'd0, 0, 2'd0, 1, oc);
        handle(oc);

        // Random traffic
        for (int n = 0; n < 80; n++) begin
            int op;
            op = int'($urandom_range(9));
            if (op < 5)
                apply(1, 2'($urandom_range(3)), 0, 2'd0, 0, oc);
            else if (op < 8)
                apply(0, 2'd0, 1, 2'($urandom_range(3)), 0, oc);
            else if (op == 8)
                apply(1'($urandom_range(1)), 2'($urandom_range(3)), 1'($urandom_range(1)),
                      2'($urandom_range(3)), 1'($urandom_range(1)), oc);
            else
                apply(0, 2'd0, 0, 2'd0, 1, oc);
            handle(oc);
        end
        if (m_credit > 0) begin
            apply(0, 2'd0, 0, 2'd0, 1, oc);
            handle(oc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
